seq_multiplier: RTL



---
 rtl/seq_multiplier.sv | 98 +++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add unsigned multiplier: one partial-product add per cycle,
// full 2*WIDTH-bit product presented on registered, held outputs.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [2*WIDTH-1:0]   mcand_r, mcand_s;
  logic [WIDTH-1:0]     mplier_r, mplier_s;
  logic [2*WIDTH-1:0]   acc_r, acc_s;
  logic [CW-1:0]        cnt_r, cnt_s;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   acc_sum_s;

  // Next-state and datapath update for the shift-add iteration.
  always_comb begin
    state_s   = state_r;
    mcand_s   = mcand_r;
    mplier_s  = mplier_r;
    acc_s     = acc_r;
    cnt_s     = cnt_r;
    prod_s    = {o_hi, o_lo};
    acc_sum_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          mcand_s  = {{WIDTH{1'b0}}, i_a};
          mplier_s = i_b;
          acc_s    = {(2*WIDTH){1'b0}};
          cnt_s    = {CW{1'b0}};
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_s    = acc_sum_s;
        mcand_s  = mcand_r << 1;
        mplier_s = mplier_r >> 1;
        cnt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        // Last iteration: publish the sum including this cycle's add.
        if (cnt_r == CW'(WIDTH - 1)) begin
          prod_s  = acc_sum_s;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; busy/done are registered decodes of the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_IDLE;
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_lo     <= {WIDTH{1'b0}};
      o_hi     <= {WIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      cnt_r    <= cnt_s;
      o_busy   <= (state_s == ST_RUN);
      o_done   <= (state_s == ST_DONE);
      o_lo     <= prod_s[WIDTH-1:0];
      o_hi     <= prod_s[2*WIDTH-1:WIDTH];
    end
  end

endmodule
